dlock_key_tx: RTL and testbench

DLOCK_KEY_TX -- requirements
Module: dlock_key_tx

---
 rtl/dlock_pkg.sv | 16 +
 rtl/dlock_bit_timer.sv | 32 +++
 rtl/dlock_key_tx.sv | 98 +++++++++
 tb/tb_dlock_key_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dlock_pkg.sv
// Shared definitions for the digital lock and its key transmitter.
// Holds the lock combination so both ends always agree on it.
package dlock_pkg;

  localparam int unsigned CODE_LEN     = 6;
  localparam logic [CODE_LEN-1:0] DEFAULT_CODE = 6'b101100;

  // Bit-period counter width; covers BIT_CYCLES up to 255.
  localparam int unsigned TIMER_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : dlock_pkg

// File: rtl/dlock_bit_timer.sv
// Bit-period down-counter: counts BIT_CYCLES clocks per bit and flags the
// last clock of each period on tc_c.
module dlock_bit_timer
  import dlock_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic tc_c
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(BIT_CYCLES);

  logic [TIMER_W-1:0] cnt;

  // With BIT_CYCLES=1 the count sits at 1, so every enabled cycle is terminal.
  assign tc_c = (cnt <= TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (load || (en && tc_c)) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

endmodule : dlock_bit_timer

// File: rtl/dlock_key_tx.sv
// Key transmitter: serialises a lock combination MSB first onto b_out,
// holding each bit for BIT_CYCLES clocks.
module dlock_key_tx
  import dlock_pkg::*;
#(
  parameter int unsigned CODE_LEN = dlock_pkg::CODE_LEN,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = CODE_LEN'(dlock_pkg::DEFAULT_CODE),
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic                use_default,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                abort,
  output logic                b_out,
  output logic                ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned BCNT_W = $clog2(CODE_LEN + 1);

  state_e              state, state_d;
  logic [CODE_LEN-1:0] shreg, shreg_d;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic                done_d;
  logic                tmr_load, tmr_en, tmr_tc_c;

  dlock_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk   (clk),
    .clear (clear),
    .load  (tmr_load),
    .en    (tmr_en),
    .tc_c  (tmr_tc_c)
  );

  // Next-state, shift and counter control.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          shreg_d   = use_default ? DEFAULT_CODE : code_in;
          bit_cnt_d = BCNT_W'(CODE_LEN);
          tmr_load  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc_c) begin
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt - BCNT_W'(1);
            if (bit_cnt == BCNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they describe; b_out is forced low outside SEND.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      b_out   <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      b_out   <= (state_d == SEND) && shreg_d[CODE_LEN-1];
      busy    <= (state_d == SEND);
      ready   <= (state_d == IDLE);
      done    <= done_d;
    end
  end

endmodule : dlock_key_tx

// File: tb/tb_dlock_key_tx.sv
// Self-checking bench for dlock_key_tx: two instances (BIT_CYCLES 1 and 3)
// checked every cycle against a scoreboard of expected output samples.
module tb_dlock_key_tx;

  localparam int unsigned L = 6;
  localparam logic [L-1:0] DEF = 6'b101100;
  // Sample packing: {b_out, busy, ready, done}
  localparam logic [3:0] EXP_IDLE = 4'b0010;
  localparam logic [3:0] EXP_DONE = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;
  logic s1, u1, a1, b1, r1, y1, d1;
  logic s3, u3, a3, b3, r3, y3, d3;
  logic [L-1:0] c1, c3;

  dlock_key_tx #(.CODE_LEN(L), .DEFAULT_CODE(DEF), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .clear(clear), .start(s1), .use_default(u1), .code_in(c1),
    .abort(a1), .b_out(b1), .ready(r1), .busy(y1), .done(d1)
  );

  dlock_key_tx #(.CODE_LEN(L), .DEFAULT_CODE(DEF), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .clear(clear), .start(s3), .use_default(u3), .code_in(c3),
    .abort(a3), .b_out(b3), .ready(r3), .busy(y3), .done(d3)
  );

  logic [3:0] q1[$];
  logic [3:0] q3[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc_no);
    end
  endtask

  // Expected samples for a transmission, first ncyc send cycles; done only if complete.
  task automatic push_tx(input int sel, input logic [L-1:0] code, input int bc, input int ncyc);
    logic [3:0] e;
    for (int k = 0; k < ncyc; k++) begin
      e = {code[L-1-(k/bc)], 1'b1, 1'b0, 1'b0};
      if (sel == 1) q1.push_back(e); else q3.push_back(e);
    end
    if (ncyc == L * bc) begin
      if (sel == 1) q1.push_back(EXP_DONE); else q3.push_back(EXP_DONE);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Push expectations only after the start cycle's own sample has been taken.
  task automatic after_sample();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    logic [3:0] e1, e3;
    if (mon_en) begin
      e1 = (q1.size() != 0) ? q1.pop_front() : EXP_IDLE;
      e3 = (q3.size() != 0) ? q3.pop_front() : EXP_IDLE;
      chk("dut1_out", 32'({b1, y1, r1, d1}), 32'(e1));
      chk("dut3_out", 32'({b3, y3, r3, d3}), 32'(e3));
    end
  end

  initial begin
    clear = 1'b1;
    s1 = 1'b0; u1 = 1'b0; a1 = 1'b0; c1 = '0;
    s3 = 1'b0; u3 = 1'b0; a3 = 1'b0; c3 = '0;
    cyc(2);
    clear = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Default send, one bit per clock.
    u1 = 1'b1; s1 = 1'b1;
    after_sample(); push_tx(1, DEF, 1, L);
    cyc(1); s1 = 1'b0; u1 = 1'b0;
    cyc(10);

    // Custom code at 3 clocks per bit; inputs disturbed during SEND.
    c3 = 6'b110010; u3 = 1'b0; s3 = 1'b1;
    after_sample(); push_tx(3, 6'b110010, 3, 3 * L);
    cyc(1); s3 = 1'b0; c3 = 6'b001101; u3 = 1'b1;
    cyc(1); s3 = 1'b1;
    cyc(1); s3 = 1'b0;
    cyc(22);

    // Abort at cycle 3 of a default send.
    u1 = 1'b1; s1 = 1'b1;
    after_sample(); push_tx(1, DEF, 1, 3);
    cyc(1); s1 = 1'b0;
    cyc(2); a1 = 1'b1;
    cyc(1); a1 = 1'b0;
    cyc(8);

    // Start with abort in IDLE, then abort alone in IDLE.
    s1 = 1'b1; a1 = 1'b1;
    cyc(1); s1 = 1'b0;
    cyc(2); a1 = 1'b0;
    cyc(2);

    // Start pulses at cycles 2-5 of a custom send are ignored.
    u1 = 1'b0; c1 = 6'b011011; s1 = 1'b1;
    after_sample(); push_tx(1, 6'b011011, 1, L);
    cyc(1); s1 = 1'b0;
    cyc(1); s1 = 1'b1; c1 = 6'b111111; u1 = 1'b1;
    cyc(4); s1 = 1'b0;
    cyc(8);

    // Back-to-back: start held high, second code taken on the done cycle.
    u1 = 1'b1; s1 = 1'b1;
    after_sample(); push_tx(1, DEF, 1, L); push_tx(1, 6'b010111, 1, L);
    cyc(1); u1 = 1'b0; c1 = 6'b010111;
    cyc(7); s1 = 1'b0;
    cyc(10);

    // Clear mid-transmission at cycle 4, new start at cycle 6.
    u1 = 1'b1; s1 = 1'b1;
    after_sample(); push_tx(1, DEF, 1, 4);
    cyc(1); s1 = 1'b0;
    cyc(3); clear = 1'b1;
    cyc(1); clear = 1'b0;
    cyc(1); u1 = 1'b0; c1 = 6'b100111; s1 = 1'b1;
    after_sample(); push_tx(1, 6'b100111, 1, L);
    cyc(1); s1 = 1'b0;
    cyc(10);

    mon_en = 1'b0;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dlock_key_tx
